// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 initiator turning a command/response handshake into APB transfers.
// Define APB_TIMEOUT_EN to enable the ACCESS-phase watchdog (TIMEOUT_CYCLES wait states).
module apb_cmd_master #(
  parameter int unsigned APB_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [APB_WIDTH-1:0]  CMD_WDATA,
  output logic                  RSP_VALID,
  output logic [APB_WIDTH-1:0]  RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [APB_WIDTH-1:0]  PWDATA,
  input  logic [APB_WIDTH-1:0]  PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W = 16;

  // Elaboration-time parameter range checks
  if (!(APB_WIDTH == 8 || APB_WIDTH == 16 || APB_WIDTH == 32)) begin : g_bad_width
    $error("apb_cmd_master: APB_WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [APB_WIDTH-1:0]  wdata;
  } cmd_t;

  state_t state;
  state_t state_nxt;
  cmd_t   cmd_q;
  logic   cmd_accept;
  logic   xfer_done;
  logic   timeout_hit;

  assign cmd_accept = (state == IDLE) && CMD_VALID;
  assign xfer_done  = (state == ACCESS) && PREADY;

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; PREADY takes priority over the watchdog
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CMD_VALID) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode from the state register and latched command
  always_comb begin
    CMD_READY = 1'b0;
    RSP_VALID = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    PADDR     = '0;
    PWDATA    = '0;
    case (state)
      IDLE:   CMD_READY = 1'b1;
      SETUP: begin
        PSEL   = 1'b1;
        PWRITE = cmd_q.write;
        PADDR  = cmd_q.addr;
        PWDATA = cmd_q.wdata;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = cmd_q.write;
        PADDR   = cmd_q.addr;
        PWDATA  = cmd_q.wdata;
      end
      RESP:    RSP_VALID = 1'b1;
      default: CMD_READY = 1'b0;
    endcase
  end

  // Command latch
  always_ff @(posedge PCLK) begin
    if (PRESET)          cmd_q <= '0;
    else if (cmd_accept) cmd_q <= {CMD_WRITE, CMD_ADDR, CMD_WDATA};
  end

  // Response data/error; read data is dropped on slave error or timeout
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else if (xfer_done) begin
      RSP_RDATA <= (!cmd_q.write && !PSLVERR) ? PRDATA : '0;
      RSP_ERR   <= PSLVERR;
    end else if (timeout_hit) begin
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b1;
    end
  end

`ifdef APB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Saturating wait-state counter, cleared when a command enters SETUP
  always_ff @(posedge PCLK) begin
    if (PRESET)
      wait_cnt <= '0;
    else if (cmd_accept)
      wait_cnt <= '0;
    else if ((state == ACCESS) && !PREADY && (wait_cnt != '1))
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK) begin
    if (PRESET)           RSP_TIMEOUT <= 1'b0;
    else if (xfer_done)   RSP_TIMEOUT <= 1'b0;
    else if (timeout_hit) RSP_TIMEOUT <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized self-checking bench for apb_cmd_master with a reactive APB slave.
// Timeout scenarios are modelled when APB_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 5;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic          CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_WDATA;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR;
  logic          RSP_TIMEOUT;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int vectors = 0;
  int errors  = 0;

  apb_cmd_master #(
    .APB_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Step to the next cycle; outputs are sampled and inputs driven 1 time unit after the edge
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) tick();
    vectors++;
    if (CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", CMD_READY); end
    vectors++;
    if ({PSEL, PENABLE, PWRITE, RSP_VALID} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {PSEL, PENABLE, PWRITE, RSP_VALID});
    end
    vectors++;
    if ({PADDR, PWDATA} !== '0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", PADDR, PWDATA); end
    vectors++;
    if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== '0) begin
      errors++; $display("FAIL reset_rsp got %h/%b/%b exp 0/0/0", RSP_RDATA, RSP_ERR, RSP_TIMEOUT);
    end
    PRESET = 1'b0;
    tick();
  endtask

  // One transfer from an IDLE cycle; the slave becomes ready on ACCESS cycle index nwait.
  task automatic run_xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int nwait,
                          input logic [DW-1:0] rd, input logic err);
    bit            to;
    int            exp_acc, exp_lat, cyc, acc, nsetup;
    bit            got;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    to      = TO_EN && (nwait > int'(TMO));
    exp_acc = to ? int'(TMO) + 1 : nwait + 1;
    exp_lat = exp_acc + 2;
    exp_rd  = (to || wr || err) ? '0 : rd;
    exp_err = to || err;

    vectors++;
    if (CMD_READY !== 1'b1) begin errors++; $display("FAIL %s idle_ready got %b exp 1", name, CMD_READY); end
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wd;
    tick();
    CMD_VALID = 1'b0; CMD_WRITE = 1'($urandom); CMD_ADDR = AW'($urandom); CMD_WDATA = $urandom;
    cyc = 1; acc = 0; nsetup = 0; got = 1'b0;
    while (!got && cyc <= 60) begin
      if (RSP_VALID === 1'b1) begin
        got = 1'b1;
      end else begin
        vectors++;
        if (CMD_READY !== 1'b0) begin errors++; $display("FAIL %s busy_ready cyc %0d got %b exp 0", name, cyc, CMD_READY); end
        if (PSEL === 1'b1) begin
          vectors++;
          if ({PWRITE, PADDR, PWDATA} !== {wr, addr, wd}) begin
            errors++; $display("FAIL %s bus_stable cyc %0d got %b/%h/%h exp %b/%h/%h",
                               name, cyc, PWRITE, PADDR, PWDATA, wr, addr, wd);
          end
        end
        if (PSEL === 1'b1 && PENABLE === 1'b0) nsetup++;
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
          PREADY  = (acc == nwait);
          PRDATA  = PREADY ? rd : $urandom;
          PSLVERR = PREADY ? err : 1'($urandom);
          acc++;
        end else begin
          PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
        tick();
        cyc++;
      end
    end
    vectors++;
    if (!got) begin
      errors++; $display("FAIL %s rsp_timeout_budget got none exp RSP_VALID at %0d", name, exp_lat);
    end else begin
      vectors++;
      if (cyc != exp_lat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, cyc, exp_lat); end
      vectors++;
      if (acc != exp_acc || nsetup != 1) begin
        errors++; $display("FAIL %s phases got access=%0d setup=%0d exp %0d/1", name, acc, nsetup, exp_acc);
      end
      vectors++;
      if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {exp_rd, exp_err, to}) begin
        errors++; $display("FAIL %s rsp got %h/%b/%b exp %h/%b/%b", name,
                           RSP_RDATA, RSP_ERR, RSP_TIMEOUT, exp_rd, exp_err, to);
      end
      vectors++;
      if ({PSEL, PENABLE, CMD_READY} !== 3'b000) begin
        errors++; $display("FAIL %s resp_ctrl got %b exp 000", name, {PSEL, PENABLE, CMD_READY});
      end
    end
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
    tick();
    vectors++;
    if ({RSP_VALID, CMD_READY} !== 2'b01) begin
      errors++; $display("FAIL %s post_idle got %b exp 01", name, {RSP_VALID, CMD_READY});
    end
    vectors++;
    if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {exp_rd, exp_err, to}) begin
      errors++; $display("FAIL %s rsp_hold got %h/%b/%b exp %h/%b/%b", name,
                         RSP_RDATA, RSP_ERR, RSP_TIMEOUT, exp_rd, exp_err, to);
    end
    PSLVERR = 1'b0;
  endtask

  task automatic test_directed();
    run_xfer("write_zero_wait", 1'b1, 8'h04, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0);
    run_xfer("read_3_wait",     1'b0, 8'h80, 32'h0000_0000, 3, 32'h0000_00F0, 1'b0);
    run_xfer("slave_error",     1'b0, 8'h10, 32'h0000_0000, 0, 32'h0000_1234, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_xfer("random", 1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, TMO + 2)),
               $urandom, ($urandom_range(0, 3) == 0));
    end
  endtask

  // Long stall: abandoned by the watchdog when enabled, otherwise completes normally
  task automatic test_timeout();
    run_xfer("long_wait_read",  1'b0, 8'h44, 32'h0,         20,  32'h5555_AAAA, 1'b0);
    run_xfer("long_wait_write", 1'b1, 8'h48, 32'h1357_9BDF, 20,  32'h0,         1'b0);
    run_xfer("ready_at_limit",  1'b0, 8'h4C, 32'h0,         int'(TMO), 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    int            acc_cyc[$];
    int            rsp_cyc[$];
    logic [DW-1:0] rsp_dat[$];
    int            ready_low;
    bit            accepted;
    logic [DW-1:0] rd;
    rd = $urandom;
    ready_low = 0;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 8'h20; CMD_WDATA = 32'hCAFE_0001;
    for (int t = 0; t < 14; t++) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin PREADY = 1'b1; PRDATA = rd; end
      else begin PREADY = 1'b0; PRDATA = $urandom; end
      PSLVERR = 1'b0;
      if (RSP_VALID === 1'b1) begin rsp_cyc.push_back(t); rsp_dat.push_back(RSP_RDATA); end
      if (acc_cyc.size() == 1 && CMD_READY === 1'b0) ready_low++;
      accepted = (CMD_VALID === 1'b1 && CMD_READY === 1'b1);
      if (accepted) acc_cyc.push_back(t);
      tick();
      if (accepted && acc_cyc.size() == 1) begin CMD_WRITE = 1'b0; CMD_ADDR = 8'h24; end
      if (accepted && acc_cyc.size() == 2) CMD_VALID = 1'b0;
    end
    PREADY = 1'b0;
    vectors++;
    if (acc_cyc.size() != 2 || rsp_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 2/2", acc_cyc.size(), rsp_cyc.size());
    end else begin
      vectors++;
      if (acc_cyc[1] - acc_cyc[0] != 4) begin errors++; $display("FAIL b2b_accept_gap got %0d exp 4", acc_cyc[1] - acc_cyc[0]); end
      vectors++;
      if (ready_low != 3) begin errors++; $display("FAIL b2b_ready_low got %0d exp 3", ready_low); end
      vectors++;
      if (rsp_cyc[0] - acc_cyc[0] != 3 || rsp_cyc[1] - rsp_cyc[0] != 4) begin
        errors++; $display("FAIL b2b_rsp_timing got %0d/%0d exp 3/4", rsp_cyc[0] - acc_cyc[0], rsp_cyc[1] - rsp_cyc[0]);
      end
      vectors++;
      if (rsp_dat[0] !== '0 || rsp_dat[1] !== rd) begin
        errors++; $display("FAIL b2b_rdata got %h/%h exp 0/%h", rsp_dat[0], rsp_dat[1], rd);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h30; CMD_WDATA = '0;
    PREADY = 1'b0;
    tick();
    CMD_VALID = 1'b0;
    tick();
    tick();
    vectors++;
    if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL rst_mid_pre got %b exp 11", {PSEL, PENABLE}); end
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    vectors++;
    if ({PSEL, PENABLE, RSP_VALID, CMD_READY} !== 4'b0001) begin
      errors++; $display("FAIL rst_mid_after got %b exp 0001", {PSEL, PENABLE, RSP_VALID, CMD_READY});
    end
    PREADY = 1'b1; PRDATA = $urandom;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({PSEL, RSP_VALID, CMD_READY} !== 3'b001) begin
        errors++; $display("FAIL rst_mid_quiet cyc %0d got %b exp 001", i, {PSEL, RSP_VALID, CMD_READY});
      end
    end
    PREADY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog got no finish exp finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-outstanding APB3 initiator; converts a simple command/response handshake into APB read and write transfers.
- Drives the APB slave side of CoreGPIO-class peripherals from fabric logic, replacing the simulation-only BFM master in real designs.
- Handles PREADY wait states and PSLVERR, with an optional watchdog timeout per transfer.

Parameters:
- APB_WIDTH, 32, data width of PWDATA/PRDATA and command data; legal values 8, 16, 32.
- ADDR_WIDTH, 8, width of PADDR and CMD_ADDR.
- TIMEOUT_CYCLES, 255, wait-state limit in the ACCESS phase; range 1..65535; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at a PCLK edge.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_WIDTH  target address.
- CMD_WDATA  in  APB_WIDTH  write data.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  APB_WIDTH  read data; 0 for writes or errors.
- RSP_ERR  out  1  PSLVERR seen or timeout.
- RSP_TIMEOUT  out  1  transfer ended by watchdog.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  APB_WIDTH  APB write data.
- PRDATA  in  APB_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clocking and reset: one clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset values: all outputs 0 except CMD_READY = 1 after reset. The state machine resets to IDLE.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - CMD_READY = 1.
  - PSEL, PENABLE, PWRITE, PADDR and PWDATA are 0.
  - On accept, latch CMD_WRITE, CMD_ADDR and CMD_WDATA, then go to SETUP.
- SETUP (exactly one cycle):
  - PSEL = 1, PENABLE = 0.
  - PADDR, PWRITE and PWDATA come from the latched command.
  - Go to ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1; address, control and data stay stable.
  - PREADY = 0: stay in ACCESS and increment the wait counter.
  - PREADY = 1:
    - Capture PRDATA into RSP_RDATA for reads; load 0 for writes.
    - Capture PSLVERR into RSP_ERR.
    - Go to RESP.
  - PSLVERR = 1 on a read: RSP_RDATA = 0 (PRDATA is discarded).
- RESP (one cycle):
  - RSP_VALID = 1; PSEL and PENABLE are 0.
  - Go to IDLE. No back-pressure on the response.
- CMD_READY is 0 in SETUP, ACCESS and RESP. Commands presented there are held off, not dropped.
- Latency: accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; RSP_VALID in cycle N+3 + wait states.
- Throughput: next accept earliest in cycle N+4, i.e. minimum 4 cycles per transfer.
- RSP_RDATA, RSP_ERR and RSP_TIMEOUT hold their values until the next RESP.
- Wait counter: 16 bits, cleared on entry to SETUP, saturating.
- Reset mid-transfer: PSEL and PENABLE drop to 0 at that edge, state returns to IDLE, and no response is issued.
- PRDATA and PSLVERR are ignored outside ACCESS with PREADY = 1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - In ACCESS, when the wait counter equals TIMEOUT_CYCLES and PREADY is still 0, the transfer is abandoned.
  - PSEL and PENABLE are 0 next cycle and the block enters RESP with RSP_ERR = 1, RSP_TIMEOUT = 1, RSP_RDATA = 0.
  - PREADY = 1 in that same cycle wins: normal completion, no timeout.
- Undefined:
  - The block waits in ACCESS indefinitely.
  - RSP_TIMEOUT is tied to 0 and the counter logic is removed.

Test Plan:
- Write, zero wait: CMD write ADDR = 0x04, WDATA = 0xA5 with PREADY = 1.
  - PSEL = 1 in cycles N+1..N+2; PENABLE = 1 in N+2 only; PADDR = 0x04, PWDATA = 0xA5, PWRITE = 1 throughout.
  - RSP_VALID in N+3 with RSP_ERR = 0, RSP_RDATA = 0.
- Read, 3 wait states: ADDR = 0x80; PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x0000_00F0.
  - RSP_VALID in N+6 with RSP_RDATA = 0xF0.
  - PADDR stable through all ACCESS cycles.
- Slave error: read ADDR = 0x10 with PREADY = 1, PSLVERR = 1, PRDATA = 0x1234.
  - RSP_ERR = 1, RSP_RDATA = 0, RSP_TIMEOUT = 0.
- Back-to-back: CMD_VALID held high for 2 commands.
  - Second accept exactly 4 cycles after the first; CMD_READY = 0 in between.
  - Two RSP_VALID pulses 4 cycles apart.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES = 5): PREADY held 0.
  - ACCESS lasts 6 cycles, then PSEL = 0.
  - RSP_VALID with RSP_ERR = 1, RSP_TIMEOUT = 1.
  - Separate run: PREADY = 1 on the 6th ACCESS cycle gives normal completion.
- Reset mid-ACCESS: PRESET = 1 for one cycle during wait states.
  - PSEL = 0 and PENABLE = 0 next cycle, no RSP_VALID, CMD_READY = 1.
